apb_controller: RTL and testbench

//  FSM that sequences AHB transfers, already captured and pipelined by ahb_slave, into APB setup/enable cycles.

---
 rtl/apb_controller_pkg.sv | 19 +
 rtl/apb_controller_if.sv | 43 ++++
 rtl/apb_controller.sv | 108 ++++++++++
 tb/tb_apb_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_controller_pkg.sv
// rtl/apb_controller_pkg.sv - shared widths and FSM state encoding for the AHB-to-APB controller
package apb_controller_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

endpackage

// File: rtl/apb_controller_if.sv
// rtl/apb_controller_if.sv - pipelined AHB beat inputs and APB bus outputs of the controller
interface apb_controller_if
  import apb_controller_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) ();

  // AHB side, already captured and pipelined by ahb_slave
  logic              Valid;
  logic              Hwrite;
  logic              Hwrite_reg;
  logic [ADDR_W-1:0] Haddr;
  logic [ADDR_W-1:0] Haddr1;
  logic [ADDR_W-1:0] Haddr2;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Hdata1;
  logic [SEL_W-1:0]  Tempselx;
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;

  // APB side
  logic [SEL_W-1:0]  Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic [DATA_W-1:0] Prdata;

  // Controller view: drives APB pins and the AHB stall
  modport master (
    input  Valid, Hwrite, Hwrite_reg, Haddr, Haddr1, Haddr2, Hwdata, Hdata1, Tempselx, Prdata,
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hrdata
  );

  // Environment view: ahb_slave plus the APB peripherals
  modport slave (
    output Valid, Hwrite, Hwrite_reg, Haddr, Haddr1, Haddr2, Hwdata, Hdata1, Tempselx, Prdata,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hrdata
  );

endinterface

// File: rtl/apb_controller.sv
// rtl/apb_controller.sv - FSM sequencing pipelined AHB beats into APB setup/enable cycles
module apb_controller
  import apb_controller_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  apb_controller_if.master   bus
);

  state_t            state;
  state_t            next_state;
  logic [SEL_W-1:0]  psel_n;
  logic              penable_n;
  logic              pwrite_n;
  logic              hready_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n;

  // Read data is returned straight from the peripheral during RENABLE
  assign bus.Hrdata = bus.Prdata;

  // Current-beat data and the one-cycle address tap are not consumed by this FSM
  logic unused_taps;
  assign unused_taps = ^{bus.Haddr1, bus.Hwdata};

  // Next state plus the APB/stall values that belong to that next state
  always_comb begin
    next_state = ST_IDLE;
    psel_n     = bus.Pselx;
    penable_n  = bus.Penable;
    pwrite_n   = bus.Pwrite;
    hready_n   = bus.Hreadyout;
    paddr_n    = bus.Paddr;
    pwdata_n   = bus.Pwdata;

    case (state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (!bus.Valid)      next_state = ST_IDLE;
        else if (bus.Hwrite) next_state = ST_WWAIT;
        else                 next_state = ST_READ;
      end
      ST_WWAIT:    next_state = bus.Valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     next_state = ST_RENABLE;
      ST_WRITE:    next_state = bus.Valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   next_state = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!bus.Hwrite_reg) next_state = ST_READ;
        else if (bus.Valid)  next_state = ST_WRITEP;
        else                 next_state = ST_WRITE;
      end
      default:     next_state = ST_IDLE;
    endcase

    // Outputs are registered with the next state so APB pins line up with state entry
    case (next_state)
      ST_READ: begin
        psel_n    = bus.Tempselx;
        paddr_n   = bus.Haddr;
        pwrite_n  = 1'b0;
        penable_n = 1'b0;
        hready_n  = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        psel_n    = bus.Tempselx;
        paddr_n   = bus.Haddr2;
        pwdata_n  = bus.Hdata1;
        pwrite_n  = 1'b1;
        penable_n = 1'b0;
        hready_n  = 1'b0;
      end
      ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
        penable_n = 1'b1;
        hready_n  = 1'b1;
      end
      default: begin
        psel_n    = '0;
        penable_n = 1'b0;
        hready_n  = 1'b1;
      end
    endcase
  end

  // State and APB output registers; reset aborts any transfer in flight
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state         <= ST_IDLE;
      bus.Pselx     <= '0;
      bus.Penable   <= 1'b0;
      bus.Pwrite    <= 1'b0;
      bus.Paddr     <= '0;
      bus.Pwdata    <= '0;
      bus.Hreadyout <= 1'b1;
    end else begin
      state         <= next_state;
      bus.Pselx     <= psel_n;
      bus.Penable   <= penable_n;
      bus.Pwrite    <= pwrite_n;
      bus.Paddr     <= paddr_n;
      bus.Pwdata    <= pwdata_n;
      bus.Hreadyout <= hready_n;
    end
  end

endmodule

// File: tb/tb_apb_controller.sv
// tb/tb_apb_controller.sv - directed self-checking bench for apb_controller
module tb_apb_controller;
  import apb_controller_pkg::*;

  logic Hclk;
  logic Hresetn;
  int   checks;
  int   errors;

  apb_controller_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) bus ();

  apb_controller #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus.master)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic set_in(input logic v, input logic hw, input logic hwr,
                        input logic [31:0] ha, input logic [31:0] ha2,
                        input logic [31:0] hd1, input logic [2:0] sel);
    bus.Valid      = v;
    bus.Hwrite     = hw;
    bus.Hwrite_reg = hwr;
    bus.Haddr      = ha;
    bus.Haddr1     = ha;
    bus.Haddr2     = ha2;
    bus.Hwdata     = hd1;
    bus.Hdata1     = hd1;
    bus.Tempselx   = sel;
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic test_reset();
    Hresetn = 1'b0;
    bus.Prdata = 32'h0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
    #12;
    checks++;
    if ({bus.Pselx, bus.Penable, bus.Hreadyout} !== {3'b000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", {bus.Pselx, bus.Penable, bus.Hreadyout}, 5'b00001);
    end
    checks++;
    if ({bus.Paddr, bus.Pwdata, bus.Pwrite} !== 65'h0) begin
      errors++;
      $display("FAIL reset_regs got %h/%h/%b want 0", bus.Paddr, bus.Pwdata, bus.Pwrite);
    end
    @(negedge Hclk);
    Hresetn = 1'b1;
    tick();
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_release_state got %0d want %0d", dut.state, ST_IDLE);
    end
  endtask

  task automatic test_single_read();
    bus.Prdata = 32'h0000_00A5;
    set_in(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 3'b001);
    tick();
    checks++;
    if (dut.state !== ST_READ) begin
      errors++;
      $display("FAIL read_state got %0d want %0d", dut.state, ST_READ);
    end
    checks++;
    if ({bus.Pselx, bus.Penable, bus.Pwrite, bus.Hreadyout, bus.Paddr} !== {3'b001, 1'b0, 1'b0, 1'b0, 32'h8000_0010}) begin
      errors++;
      $display("FAIL read_setup got sel=%b en=%b wr=%b rdy=%b addr=%h want sel=001 en=0 wr=0 rdy=0 addr=80000010",
               bus.Pselx, bus.Penable, bus.Pwrite, bus.Hreadyout, bus.Paddr);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'hDEAD_0000, 32'h0, 32'h0, 3'b100);
    tick();
    checks++;
    if ({dut.state, bus.Pselx, bus.Penable, bus.Hreadyout, bus.Paddr, bus.Hrdata} !==
        {ST_RENABLE, 3'b001, 1'b1, 1'b1, 32'h8000_0010, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL read_enable got st=%0d sel=%b en=%b rdy=%b addr=%h rdata=%h want st=5 sel=001 en=1 rdy=1 addr=80000010 rdata=a5",
               dut.state, bus.Pselx, bus.Penable, bus.Hreadyout, bus.Paddr, bus.Hrdata);
    end
    tick();
    checks++;
    if ({dut.state, bus.Pselx, bus.Penable, bus.Paddr} !== {ST_IDLE, 3'b000, 1'b0, 32'h8000_0010}) begin
      errors++;
      $display("FAIL read_idle got st=%0d sel=%b en=%b addr=%h want st=0 sel=000 en=0 addr=80000010",
               dut.state, bus.Pselx, bus.Penable, bus.Paddr);
    end
  endtask

  task automatic test_single_write();
    set_in(1'b1, 1'b1, 1'b0, 32'h8400_0020, 32'h0, 32'h0, 3'b010);
    tick();
    checks++;
    if ({dut.state, bus.Pselx, bus.Hreadyout} !== {ST_WWAIT, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL write_wwait got st=%0d sel=%b rdy=%b want st=1 sel=000 rdy=1", dut.state, bus.Pselx, bus.Hreadyout);
    end
    set_in(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h8400_0020, 32'h0000_0055, 3'b010);
    tick();
    checks++;
    if ({dut.state, bus.Pselx, bus.Penable, bus.Pwrite, bus.Hreadyout, bus.Paddr, bus.Pwdata} !==
        {ST_WRITE, 3'b010, 1'b0, 1'b1, 1'b0, 32'h8400_0020, 32'h0000_0055}) begin
      errors++;
      $display("FAIL write_setup got st=%0d sel=%b en=%b wr=%b rdy=%b addr=%h data=%h want st=3 sel=010 en=0 wr=1 rdy=0 addr=84000020 data=55",
               dut.state, bus.Pselx, bus.Penable, bus.Pwrite, bus.Hreadyout, bus.Paddr, bus.Pwdata);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
    checks++;
    if ({dut.state, bus.Pselx, bus.Penable, bus.Hreadyout, bus.Pwdata} !== {ST_WENABLE, 3'b010, 1'b1, 1'b1, 32'h0000_0055}) begin
      errors++;
      $display("FAIL write_enable got st=%0d sel=%b en=%b rdy=%b data=%h want st=6 sel=010 en=1 rdy=1 data=55",
               dut.state, bus.Pselx, bus.Penable, bus.Hreadyout, bus.Pwdata);
    end
    tick();
    checks++;
    if ({dut.state, bus.Penable} !== {ST_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL write_idle got st=%0d en=%b want st=0 en=0", dut.state, bus.Penable);
    end
  endtask

  task automatic test_back_to_back();
    logic        v   [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic        hw  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic        hwr [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    logic [31:0] a2  [8] = '{32'h0, 32'h8400_0000, 32'hFFFF_FFFC, 32'h8400_0004,
                             32'hFFFF_FFFC, 32'h8400_0008, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    logic [31:0] d1  [8] = '{32'h0, 32'h11, 32'hEE, 32'h22, 32'hEE, 32'h33, 32'hEE, 32'hEE};
    state_t      es  [8] = '{ST_WWAIT, ST_WRITEP, ST_WENABLEP, ST_WRITEP,
                             ST_WENABLEP, ST_WRITE, ST_WENABLE, ST_IDLE};
    logic [2:0]  eps [8] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    logic        ep  [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
    logic [31:0] ea  [8] = '{32'h8400_0020, 32'h8400_0000, 32'h8400_0000, 32'h8400_0004,
                             32'h8400_0004, 32'h8400_0008, 32'h8400_0008, 32'h8400_0008};
    logic [31:0] ed  [8] = '{32'h55, 32'h11, 32'h11, 32'h22, 32'h22, 32'h33, 32'h33, 32'h33};
    logic        prev_en;
    prev_en = bus.Penable;
    for (int i = 0; i < 8; i++) begin
      set_in(v[i], hw[i], hwr[i], 32'hC000_0000, a2[i], d1[i], 3'b010);
      tick();
      checks++;
      if (dut.state !== es[i]) begin
        errors++;
        $display("FAIL b2b_state step %0d got %0d want %0d", i, dut.state, es[i]);
      end
      checks++;
      if ({bus.Pselx, bus.Penable, bus.Paddr, bus.Pwdata} !== {eps[i], ep[i], ea[i], ed[i]}) begin
        errors++;
        $display("FAIL b2b_bus step %0d got sel=%b en=%b addr=%h data=%h want sel=%b en=%b addr=%h data=%h",
                 i, bus.Pselx, bus.Penable, bus.Paddr, bus.Pwdata, eps[i], ep[i], ea[i], ed[i]);
      end
      checks++;
      if (prev_en && bus.Penable) begin
        errors++;
        $display("FAIL b2b_enable_twice step %0d got en=1 after en=1 want en=0", i);
      end
      prev_en = bus.Penable;
    end
  endtask

  task automatic test_write_then_read();
    set_in(1'b1, 1'b1, 1'b0, 32'h8400_0040, 32'h0, 32'h0, 3'b010);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 32'h8000_0050, 32'h8400_0040, 32'h0000_0077, 3'b010);
    tick();
    checks++;
    if ({dut.state, bus.Paddr, bus.Pwdata} !== {ST_WRITEP, 32'h8400_0040, 32'h0000_0077}) begin
      errors++;
      $display("FAIL wr_rd_writep got st=%0d addr=%h data=%h want st=4 addr=84000040 data=77", dut.state, bus.Paddr, bus.Pwdata);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h8000_0050, 32'h0, 32'h0, 3'b001);
    tick();
    checks++;
    if ({dut.state, bus.Penable} !== {ST_WENABLEP, 1'b1}) begin
      errors++;
      $display("FAIL wr_rd_wenablep got st=%0d en=%b want st=7 en=1", dut.state, bus.Penable);
    end
    tick();
    checks++;
    if ({dut.state, bus.Pselx, bus.Penable, bus.Pwrite, bus.Hreadyout, bus.Paddr} !==
        {ST_READ, 3'b001, 1'b0, 1'b0, 1'b0, 32'h8000_0050}) begin
      errors++;
      $display("FAIL wr_rd_read got st=%0d sel=%b en=%b wr=%b rdy=%b addr=%h want st=2 sel=001 en=0 wr=0 rdy=0 addr=80000050",
               dut.state, bus.Pselx, bus.Penable, bus.Pwrite, bus.Hreadyout, bus.Paddr);
    end
    tick();
    tick();
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL wr_rd_idle got %0d want %0d", dut.state, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid_transfer();
    set_in(1'b1, 1'b1, 1'b0, 32'h8800_0000, 32'h0, 32'h0, 3'b100);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'h0, 32'h8800_0000, 32'h0000_0099, 3'b100);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
    checks++;
    if ({dut.state, bus.Pselx, bus.Penable} !== {ST_WENABLE, 3'b100, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_pre got st=%0d sel=%b en=%b want st=6 sel=100 en=1", dut.state, bus.Pselx, bus.Penable);
    end
    #2;
    Hresetn = 1'b0;
    #1;
    checks++;
    if ({dut.state, bus.Pselx, bus.Penable, bus.Hreadyout, bus.Paddr} !== {ST_IDLE, 3'b000, 1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_async got st=%0d sel=%b en=%b rdy=%b addr=%h want st=0 sel=000 en=0 rdy=1 addr=0",
               dut.state, bus.Pselx, bus.Penable, bus.Hreadyout, bus.Paddr);
    end
    @(negedge Hclk);
    Hresetn = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_write_then_read();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
